// File: rtl/channel_sounder_pkg.sv
// Shared sizing and reader FSM encoding for the channel sounder.
// The accumulator and the result reader both import this package.
package channel_sounder_pkg;

  localparam int ADDR_WIDTH_DEF = 10;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int NUM_BINS_DEF   = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/result_bram_reader_if.sv
// AXI4-Stream beat bundle: data, last, valid/ready handshake.
// The master drives the beat; the slave drives ready.
interface result_bram_reader_if #(
  parameter int DATA_WIDTH = 64
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (
    output tdata, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tlast, tvalid,
    output tready
  );

endinterface

// File: rtl/axis_fifo2.sv
// Two-entry stream FIFO holding {last, data}.
// The head drives the stream directly, so it holds while stalled.
module axis_fifo2 #(
  parameter int DATA_WIDTH = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_WIDTH:0] wr_data,
  output logic [1:0]        count,
  result_bram_reader_if.master m
);

  logic [DATA_WIDTH:0] mem0;
  logic [DATA_WIDTH:0] mem1;
  logic                rd_ptr;
  logic                wr_ptr;
  logic                pop;

  assign pop      = m.tvalid & m.tready;
  assign m.tvalid = (count != 2'd0);
  assign {m.tlast, m.tdata} = rd_ptr ? mem1 : mem0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0   <= '0;
      mem1   <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr_en) begin
        if (wr_ptr) mem1 <= wr_data;
        else        mem0 <= wr_data;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, wr_en} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/result_bram_reader.sv
// Streams one frame of result bins from BRAM out over AXI4-Stream.
// Reads are credit-limited so the 2-entry FIFO can never overflow.
module result_bram_reader
  import channel_sounder_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_BINS   = NUM_BINS_DEF
) (
  input  logic                  m00_axis_aclk,
  input  logic                  m00_axis_aresetn,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] result_bram_addr_read,
  output logic                  result_bram_r_enable,
  input  logic [DATA_WIDTH-1:0] result_bram_datain,
  output logic [DATA_WIDTH-1:0] M00_AXIS_tdata,
  output logic                  M00_AXIS_tvalid,
  input  logic                  M00_AXIS_tready,
  output logic                  M00_AXIS_tlast,
  output logic                  start_ignored
);

  localparam int AW1 = ADDR_WIDTH + 1;
  localparam logic [AW1-1:0] LAST_ADDR = AW1'(NUM_BINS - 1);

  rd_state_e      state;
  logic [AW1-1:0] addr;
  logic           in_flight;
  logic           tag_last;
  logic           armed;
  logic [1:0]     fifo_cnt;
  logic [1:0]     level;
  logic           accept;
  logic           ren;
  logic           last_rd;
  logic           take;

  result_bram_reader_if #(.DATA_WIDTH(DATA_WIDTH)) m_axis ();

  axis_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk     (m00_axis_aclk),
    .rst_n   (m00_axis_aresetn),
    .wr_en   (in_flight),
    .wr_data ({tag_last, result_bram_datain}),
    .count   (fifo_cnt),
    .m       (m_axis)
  );

  assign M00_AXIS_tdata  = m_axis.tdata;
  assign M00_AXIS_tlast  = m_axis.tlast;
  assign M00_AXIS_tvalid = m_axis.tvalid;
  assign m_axis.tready   = M00_AXIS_tready;

  assign accept = M00_AXIS_tvalid & M00_AXIS_tready;
  assign level  = fifo_cnt + {1'b0, in_flight};

  // A beat leaving this cycle frees a slot for a read issued now.
  assign ren = (state == READ) &&
               ((level < 2'd2) || ((level == 2'd2) && accept));
  assign last_rd = ren && (addr == LAST_ADDR);
  assign take    = start && armed;

  assign result_bram_r_enable  = ren;
  assign result_bram_addr_read = addr[ADDR_WIDTH-1:0];

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state         <= IDLE;
      addr          <= '0;
      in_flight     <= 1'b0;
      tag_last      <= 1'b0;
      armed         <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      start_ignored <= 1'b0;
    end else begin
      armed     <= 1'b1;
      in_flight <= ren;
      done      <= 1'b0;
      if (ren) begin
        addr     <= addr + 1'b1;
        tag_last <= last_rd;
      end
      if (take && (busy || done)) start_ignored <= 1'b1;
      unique case (state)
        IDLE: begin
          if (take && !done) begin
            state <= READ;
            addr  <= '0;
            busy  <= 1'b1;
          end
        end
        READ: begin
          if (last_rd) state <= DRAIN;
        end
        DRAIN: begin
          if (accept && M00_AXIS_tlast) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_bram_reader.sv
// Directed bench for result_bram_reader with a 1-cycle BRAM model.
// Beats, reads and done pulses are logged at the falling edge.
module tb_result_bram_reader;

  localparam int AW = 10;
  localparam int DW = 64;
  localparam int NB = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          ren;
  logic          start_ignored;
  logic [AW-1:0] raddr;
  logic [DW-1:0] bram_q = '0;

  result_bram_reader_if #(.DATA_WIDTH(DW)) axis ();

  result_bram_reader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_BINS   (NB)
  ) dut (
    .m00_axis_aclk         (clk),
    .m00_axis_aresetn      (rst_n),
    .start                 (start),
    .busy                  (busy),
    .done                  (done),
    .result_bram_addr_read (raddr),
    .result_bram_r_enable  (ren),
    .result_bram_datain    (bram_q),
    .M00_AXIS_tdata        (axis.tdata),
    .M00_AXIS_tvalid       (axis.tvalid),
    .M00_AXIS_tready       (axis.tready),
    .M00_AXIS_tlast        (axis.tlast),
    .start_ignored         (start_ignored)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] word(input int i);
    logic [31:0] u;
    u = 32'(i);
    return {32'hA5A5_0000 + u, ~u};
  endfunction

  always @(posedge clk) if (ren) bram_q <= word(int'(raddr));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int c0;

  logic [63:0] q_data[$];
  logic        q_last[$];
  int          q_cyc[$];
  int          done_cyc[$];
  int          rd_cnt;
  int          first_ren_cyc;
  int          first_ren_addr;
  int          hold_err;
  int          level_err;
  bit          prev_hold;
  logic [63:0] prev_data;
  logic        prev_last;
  int          stall_start;
  int          rd_b;
  int          rd_e;

  task automatic clear_mon();
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
    done_cyc.delete();
    rd_cnt = 0;
    first_ren_cyc = -1;
    first_ren_addr = -1;
    hold_err = 0;
    level_err = 0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (rd_cnt - q_data.size() > 2) level_err++;
      if (prev_hold && (axis.tdata !== prev_data ||
                        axis.tlast !== prev_last)) hold_err++;
      prev_hold = axis.tvalid && !axis.tready;
      prev_data = axis.tdata;
      prev_last = axis.tlast;
      if (ren) begin
        if (rd_cnt == 0) begin
          first_ren_cyc = cyc - c0;
          first_ren_addr = int'(raddr);
        end
        rd_cnt++;
      end
      if (axis.tvalid && axis.tready) begin
        q_data.push_back(axis.tdata);
        q_last.push_back(axis.tlast);
        q_cyc.push_back(cyc - c0);
      end
      if (done) done_cyc.push_back(cyc - c0);
    end
  end

  function automatic int frame_errs();
    int e;
    e = 0;
    if (q_data.size() != NB) return NB + 1;
    for (int i = 0; i < NB; i++) begin
      if (q_data[i] !== word(i)) e++;
      if (q_last[i] !== (i == NB - 1)) e++;
    end
    return e;
  endfunction

  // mode: 0 ready, 1 alternating, 2 stall at 500, 3 start at 300, 4 reset at 700
  task automatic run_frame(input int mode, output bit timeout);
    bit ign;
    clear_mon();
    c0 = cyc;
    start = 1'b1;
    axis.tready = 1'b1;
    timeout = 1'b1;
    stall_start = -1;
    rd_b = 0;
    rd_e = -1;
    ign = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done_cyc.size() > 0) begin
        timeout = 1'b0;
        break;
      end
      case (mode)
        1: axis.tready = (n % 2 == 1);
        2: begin
          if (stall_start < 0 && q_data.size() >= 500) begin
            stall_start = n;
            rd_b = rd_cnt;
          end
          if (stall_start >= 0 && n == stall_start + 50) rd_e = rd_cnt;
          axis.tready = !(stall_start >= 0 && n < stall_start + 50);
        end
        3: begin
          if (!ign && q_data.size() >= 300) begin
            start = 1'b1;
            ign = 1'b1;
          end
        end
        4: begin
          if (q_data.size() >= 700) begin
            rst_n = 1'b0;
            timeout = 1'b0;
            break;
          end
        end
        default: axis.tready = 1'b1;
      endcase
    end
    if (mode != 4) axis.tready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    axis.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done got=%b exp=0", done);
    end
    checks++;
    if (ren !== 1'b0 || raddr !== '0) begin
      failures++;
      $display("FAIL reset_read got ren=%b addr=%0d exp 0/0", ren, raddr);
    end
    checks++;
    if (axis.tvalid !== 1'b0 || axis.tlast !== 1'b0) begin
      failures++;
      $display("FAIL reset_stream got v=%b l=%b exp 0/0",
               axis.tvalid, axis.tlast);
    end
    checks++;
    if (axis.tdata !== 64'h0) begin
      failures++;
      $display("FAIL reset_tdata got=%h exp=0", axis.tdata);
    end
    checks++;
    if (start_ignored !== 1'b0) begin
      failures++;
      $display("FAIL reset_ignored got=%b exp=0", start_ignored);
    end
    rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    clear_mon();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || rd_cnt !== 0) begin
      failures++;
      $display("FAIL first_cycle_start got busy=%b reads=%0d exp 0/0",
               busy, rd_cnt);
    end
  endtask

  task automatic test_full_throughput();
    bit to;
    int gaps;
    run_frame(0, to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL full_timeout got=timeout exp=done");
    end
    checks++;
    if (first_ren_cyc !== 1 || first_ren_addr !== 0) begin
      failures++;
      $display("FAIL full_first_read got cyc=%0d addr=%0d exp 1/0",
               first_ren_cyc, first_ren_addr);
    end
    checks++;
    if (frame_errs() !== 0) begin
      failures++;
      $display("FAIL full_data got errs=%0d exp=0", frame_errs());
    end
    gaps = 0;
    for (int i = 0; i < q_cyc.size(); i++)
      if (q_cyc[i] != 3 + i) gaps++;
    checks++;
    if (gaps !== 0 || q_cyc.size() !== NB) begin
      failures++;
      $display("FAIL full_timing got bad=%0d n=%0d exp 0/%0d",
               gaps, q_cyc.size(), NB);
    end
    checks++;
    if (q_cyc.size() == NB && q_cyc[NB-1] !== 1026) begin
      failures++;
      $display("FAIL full_tlast_cycle got=%0d exp=1026", q_cyc[NB-1]);
    end
    checks++;
    if (done_cyc.size() == 0 || done_cyc[0] !== 1027) begin
      failures++;
      $display("FAIL full_done_cycle got=%0d exp=1027",
               done_cyc.size() ? done_cyc[0] : -1);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL full_busy_end got=%b exp=0", busy);
    end
  endtask

  task automatic test_alternating();
    bit to;
    run_frame(1, to);
    checks++;
    if (to || frame_errs() !== 0) begin
      failures++;
      $display("FAIL alt_data got timeout=%b errs=%0d exp 0/0",
               to, frame_errs());
    end
    checks++;
    if (hold_err !== 0) begin
      failures++;
      $display("FAIL alt_hold got=%0d exp=0", hold_err);
    end
    checks++;
    if (level_err !== 0) begin
      failures++;
      $display("FAIL alt_credit got=%0d exp=0", level_err);
    end
  endtask

  task automatic test_stall();
    bit to;
    run_frame(2, to);
    checks++;
    if (to || frame_errs() !== 0) begin
      failures++;
      $display("FAIL stall_data got timeout=%b errs=%0d exp 0/0",
               to, frame_errs());
    end
    checks++;
    if (rd_e < 0 || rd_e - rd_b > 2) begin
      failures++;
      $display("FAIL stall_reads got=%0d exp<=2", rd_e - rd_b);
    end
    checks++;
    if (q_cyc.size() <= 500 || q_cyc[500] !== stall_start + 51) begin
      failures++;
      $display("FAIL stall_resume got=%0d exp=%0d",
               q_cyc.size() > 500 ? q_cyc[500] : -1, stall_start + 51);
    end
    checks++;
    if (hold_err !== 0 || level_err !== 0) begin
      failures++;
      $display("FAIL stall_hold got hold=%0d lvl=%0d exp 0/0",
               hold_err, level_err);
    end
  endtask

  task automatic test_start_while_busy();
    bit to;
    run_frame(3, to);
    checks++;
    if (to || frame_errs() !== 0) begin
      failures++;
      $display("FAIL busy_start_data got timeout=%b errs=%0d exp 0/0",
               to, frame_errs());
    end
    checks++;
    if (done_cyc.size() == 0 || done_cyc[0] !== 1027) begin
      failures++;
      $display("FAIL busy_start_done got=%0d exp=1027",
               done_cyc.size() ? done_cyc[0] : -1);
    end
    checks++;
    if (start_ignored !== 1'b1) begin
      failures++;
      $display("FAIL busy_start_flag got=%b exp=1", start_ignored);
    end
    run_frame(0, to);
    checks++;
    if (to || frame_errs() !== 0 || start_ignored !== 1'b1) begin
      failures++;
      $display("FAIL sticky_flag got flag=%b errs=%0d exp 1/0",
               start_ignored, frame_errs());
    end
  endtask

  task automatic test_reset_mid_frame();
    bit to;
    run_frame(4, to);
    #1;
    checks++;
    if (axis.tvalid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_idle got v=%b busy=%b exp 0/0",
               axis.tvalid, busy);
    end
    checks++;
    if (start_ignored !== 1'b0 || ren !== 1'b0) begin
      failures++;
      $display("FAIL midreset_flags got ign=%b ren=%b exp 0/0",
               start_ignored, ren);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    run_frame(0, to);
    checks++;
    if (to || frame_errs() !== 0 || first_ren_addr !== 0) begin
      failures++;
      $display("FAIL midreset_restart got errs=%0d addr=%0d exp 0/0",
               frame_errs(), first_ren_addr);
    end
    checks++;
    if (q_cyc.size() == 0 || q_cyc[0] !== 3) begin
      failures++;
      $display("FAIL midreset_first_beat got=%0d exp=3",
               q_cyc.size() ? q_cyc[0] : -1);
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    run_frame(0, to);
    checks++;
    if (to || frame_errs() !== 0) begin
      failures++;
      $display("FAIL b2b_first got timeout=%b errs=%0d exp 0/0",
               to, frame_errs());
    end
    run_frame(0, to);
    checks++;
    if (to || frame_errs() !== 0) begin
      failures++;
      $display("FAIL b2b_second got timeout=%b errs=%0d exp 0/0",
               to, frame_errs());
    end
    checks++;
    if (q_cyc.size() == 0 || q_cyc[0] !== 3 || done_cyc[0] !== 1027) begin
      failures++;
      $display("FAIL b2b_timing got first=%0d done=%0d exp 3/1027",
               q_cyc.size() ? q_cyc[0] : -1,
               done_cyc.size() ? done_cyc[0] : -1);
    end
    checks++;
    if (start_ignored !== 1'b0) begin
      failures++;
      $display("FAIL b2b_flag got=%b exp=0", start_ignored);
    end
  endtask

  initial begin
    clear_mon();
    c0 = 0;
    test_reset();
    test_full_throughput();
    test_alternating();
    test_stall();
    test_start_while_busy();
    test_reset_mid_frame();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
